// File: rtl/dds_lut_arb.sv
// Two-voice arbiter sharing one DDS sine LUT: IDLE -> ISSUE -> CAPTURE, round-robin on ties.
// Define DDS_ARB_FIXED_PRIO_EN to make voice 0 always win a tie instead.
module dds_lut_arb #(
    parameter int PHASE_W = 14,
    parameter int DATA_W  = 12
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req0,
    input  logic               req1,
    input  logic [PHASE_W-1:0] phase0,
    input  logic [PHASE_W-1:0] phase1,
    output logic               gnt0,
    output logic               gnt1,
    output logic [PHASE_W-1:0] lut_addr,
    output logic               lut_rd,
    input  logic [DATA_W-1:0]  lut_data,
    output logic [DATA_W-1:0]  data0,
    output logic [DATA_W-1:0]  data1,
    output logic               vld0,
    output logic               vld1,
    output logic               busy
);

    localparam logic [1:0] StIdle    = 2'd0;
    localparam logic [1:0] StIssue   = 2'd1;
    localparam logic [1:0] StCapture = 2'd2;

    logic [1:0] state_q, state_d;
    logic       owner_q;
    logic       decide;
    logic       winner;

`ifdef DDS_ARB_FIXED_PRIO_EN
    assign winner = ~req0;
`else
    // last_q = 1 means voice 1 was served most recently
    logic last_q;
    assign winner = (req0 && req1) ? ~last_q : req1;
`endif

    always_comb begin
        state_d = state_q;
        decide  = 1'b0;
        case (state_q)
            StIdle: begin
                if (req0 || req1) begin
                    decide  = 1'b1;
                    state_d = StIssue;
                end
            end
            StIssue: state_d = StCapture;
            StCapture: begin
                if (req0 || req1) begin
                    decide  = 1'b1;
                    state_d = StIssue;
                end else begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            owner_q  <= 1'b0;
            lut_addr <= '0;
            data0    <= '0;
            data1    <= '0;
            vld0     <= 1'b0;
            vld1     <= 1'b0;
`ifndef DDS_ARB_FIXED_PRIO_EN
            last_q   <= 1'b1;
`endif
        end else begin
            state_q <= state_d;
            vld0    <= 1'b0;
            vld1    <= 1'b0;
            if (state_q == StCapture) begin
                if (owner_q) begin
                    data1 <= lut_data;
                    vld1  <= 1'b1;
                end else begin
                    data0 <= lut_data;
                    vld0  <= 1'b1;
                end
            end
            if (decide) begin
                owner_q  <= winner;
                lut_addr <= winner ? phase1 : phase0;
`ifndef DDS_ARB_FIXED_PRIO_EN
                last_q   <= winner;
`endif
            end
        end
    end

    assign gnt0   = (state_q == StIssue) && !owner_q;
    assign gnt1   = (state_q == StIssue) && owner_q;
    assign lut_rd = (state_q == StIssue);
    assign busy   = (state_q != StIdle);

endmodule

// File: tb/tb_dds_lut_arb.sv
// Scoreboard bench for dds_lut_arb: requester model, LUT model, per-voice expected-data queues.
module tb_dds_lut_arb;

    localparam int PW = 14;
    localparam int DW = 12;

    logic          clk;
    logic          rst_n;
    logic [1:0]    req_r;
    logic [PW-1:0] ph [2];
    logic          gnt0, gnt1, lut_rd, vld0, vld1, busy;
    logic [PW-1:0] lut_addr;
    logic [DW-1:0] lut_data, data0, data1;

    dds_lut_arb #(.PHASE_W(PW), .DATA_W(DW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req0     (req_r[0]),
        .req1     (req_r[1]),
        .phase0   (ph[0]),
        .phase1   (ph[1]),
        .gnt0     (gnt0),
        .gnt1     (gnt1),
        .lut_addr (lut_addr),
        .lut_rd   (lut_rd),
        .lut_data (lut_data),
        .data0    (data0),
        .data1    (data1),
        .vld0     (vld0),
        .vld1     (vld1),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DW-1:0] lut_f(input logic [PW-1:0] a);
        return a[11:0] ^ 12'hB9F ^ {10'd0, a[13:12]};
    endfunction

    // LUT returns data the cycle after a read; junk otherwise
    always @(posedge clk) begin
        if (lut_rd) lut_data <= lut_f(lut_addr);
        else        lut_data <= DW'($urandom);
    end

    int            total = 0;
    int            bad   = 0;
    int            left [2];
    int            gap  [2];
    logic [PW-1:0] nph  [2];
    logic [DW-1:0] last_d0, last_d1;
    logic [DW-1:0] exp_d0 [$];
    logic [DW-1:0] exp_d1 [$];
    logic          exp_gnt [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, want);
        end
    endtask

    task automatic monitor();
        logic v;
        check("gnt_excl", {31'd0, gnt0 & gnt1}, 0);
        check("rd_is_gnt", {31'd0, lut_rd}, {31'd0, gnt0 | gnt1});
        if (gnt0 || gnt1) begin
            v = gnt1;
            if (exp_gnt.size() > 0) check("gnt_order", {31'd0, v}, {31'd0, exp_gnt.pop_front()});
            check("gnt_addr", {18'd0, lut_addr}, {18'd0, ph[v]});
        end
        if (vld0) begin
            if (exp_d0.size() == 0) check("vld0_extra", 1, 0);
            else last_d0 = exp_d0.pop_front();
        end
        if (vld1) begin
            if (exp_d1.size() == 0) check("vld1_extra", 1, 0);
            else last_d1 = exp_d1.pop_front();
        end
        check("data0", {20'd0, data0}, {20'd0, last_d0});
        check("data1", {20'd0, data1}, {20'd0, last_d1});
    endtask

    // Drops req on grant, waits one cycle, then re-raises if more reads remain
    task automatic requester();
        logic [1:0] g;
        g = {gnt1, gnt0};
        for (int v = 0; v < 2; v++) begin
            if (req_r[v] && g[v]) begin
                req_r[v] = 1'b0;
                gap[v]   = 1;
            end else if (gap[v] != 0) begin
                gap[v]--;
            end else if (left[v] > 0 && !req_r[v]) begin
                req_r[v] = 1'b1;
                ph[v]    = nph[v];
                nph[v]   = nph[v] + PW'(14'h0111);
                left[v]--;
                if (v == 0) exp_d0.push_back(lut_f(ph[v]));
                else        exp_d1.push_back(lut_f(ph[v]));
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        monitor();
        requester();
    endtask

    task automatic drain(input int max);
        int n;
        logic pend;
        n = 0;
        pend = 1'b1;
        while (pend && n < max) begin
            step();
            n++;
            pend = (exp_d0.size() != 0) || (exp_d1.size() != 0) || busy ||
                   (left[0] != 0) || (left[1] != 0);
        end
        check("drain_done", {31'd0, pend}, 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        exp_d0.delete();
        exp_d1.delete();
        exp_gnt.delete();
        last_d0 = '0;
        last_d1 = '0;
        for (int v = 0; v < 2; v++) begin
            left[v] = 0;
            gap[v]  = 0;
        end
        step();
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_vld", {30'd0, vld1, vld0}, 0);
        check("rst_gnt", {29'd0, lut_rd, gnt1, gnt0}, 0);
        check("rst_addr", {18'd0, lut_addr}, 0);
        req_r = 2'b11;
        step();
        step();
        check("rst_ignore_req", {28'd0, busy, lut_rd, gnt1, gnt0}, 0);
        req_r = 2'b00;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        req_r = 2'b00;
        ph[0] = '0;
        ph[1] = '0;
        nph[0] = '0;
        nph[1] = '0;
        do_reset();

        // single read latency
        left[0] = 1;
        nph[0]  = 14'h0123;
        step();
        step();
        check("lat_gnt0", {31'd0, gnt0}, 1);
        check("lat_rd", {31'd0, lut_rd}, 1);
        check("lat_addr", {18'd0, lut_addr}, 32'h123);
        step();
        check("lat_cap_gnt", {31'd0, gnt0}, 0);
        check("lat_cap_busy", {31'd0, busy}, 1);
        step();
        check("lat_vld0", {31'd0, vld0}, 1);
        check("lat_data0", {20'd0, data0}, 32'hABC);
        check("lat_idle", {31'd0, busy}, 0);
        drain(10);

        // first tie after reset goes to voice 0, voice 1 two cycles later
        do_reset();
        left[0] = 1;
        left[1] = 1;
        nph[0]  = 14'h0010;
        nph[1]  = 14'h0020;
        exp_gnt.push_back(1'b0);
        exp_gnt.push_back(1'b1);
        step();
        step();
        check("tie_gnt0", {30'd0, gnt1, gnt0}, 1);
        step();
        step();
        check("tie_gnt1", {30'd0, gnt1, gnt0}, 2);
        check("tie_vld0", {31'd0, vld0}, 1);
        step();
        step();
        check("tie_vld1", {31'd0, vld1}, 1);
        check("tie_d1", {20'd0, data1}, {20'd0, lut_f(14'h0020)});
        drain(10);

        // continuous demand alternates 0,1,0,1...
        left[0] = 4;
        left[1] = 4;
        nph[0]  = 14'h0400;
        nph[1]  = 14'h3001;
        for (int i = 0; i < 4; i++) begin
            exp_gnt.push_back(1'b0);
            exp_gnt.push_back(1'b1);
        end
        drain(60);
        check("alt_all_granted", exp_gnt.size(), 0);

        // back-to-back: voice 1 raised during voice 0 read
        left[0] = 1;
        nph[0]  = 14'h1555;
        nph[1]  = 14'h2AAA;
        step();
        left[1] = 1;
        step();
        check("b2b_gnt0", {31'd0, gnt0}, 1);
        step();
        check("b2b_gap_rd", {31'd0, lut_rd}, 0);
        step();
        check("b2b_vld0_gnt1", {29'd0, lut_rd, gnt1, vld0}, 7);
        drain(10);

        // reset during CAPTURE aborts the read
        left[0] = 1;
        nph[0]  = 14'h0777;
        step();
        step();
        check("abort_gnt0", {31'd0, gnt0}, 1);
        step();
        check("abort_in_cap", {31'd0, busy}, 1);
        rst_n = 1'b0;
        exp_d0.delete();
        last_d0 = '0;
        last_d1 = '0;
        step();
        check("abort_vld", {30'd0, vld1, vld0}, 0);
        check("abort_data0", {20'd0, data0}, 0);
        check("abort_busy", {31'd0, busy}, 0);
        rst_n = 1'b1;
        left[0] = 1;
        left[1] = 1;
        nph[0]  = 14'h0100;
        nph[1]  = 14'h0200;
        exp_gnt.push_back(1'b0);
        exp_gnt.push_back(1'b1);
        step();
        step();
        check("abort_tie_gnt0", {30'd0, gnt1, gnt0}, 1);
        drain(20);

        check("gnt_queue_empty", exp_gnt.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
